// File: rtl/exec_mdu_unit.sv
// exec_mdu_unit: single-cycle ALU plus iterative shift-add multiplier and
// optional restoring divider, with branch resolution on the produced result.
// Optional feature macro: EXEC_MDU_DIV_EN (enables DIVU/REMU and the DIV state).
module exec_mdu_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       br_cond,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] br_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] pc_out,
  output logic             br_taken,
  output logic             illegal_op,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
`ifdef EXEC_MDU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] opa_q, opa_d;     // MUL multiplier (shifts right) / DIV dividend->quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // MUL multiplicand (shifts left) / DIV divisor
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [1:0]       cond_q, cond_d;
`ifdef EXEC_MDU_DIV_EN
  logic             rem_sel_q, rem_sel_d;
`endif

  logic             out_valid_d, br_taken_d, illegal_d;
  logic [WIDTH-1:0] result_d, pc_out_d;

  logic             slot_free;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] mul_acc_nx;
  logic             fin_done;
  logic [WIDTH-1:0] fin_res;

  // Branch decision on a finished result.
  function automatic logic br_eval(input logic [WIDTH-1:0] r, input logic [1:0] c);
    logic t;
    t = 1'b0;
    case (c)
      2'd1:    t = (r == '0);
      2'd2:    t = (r != '0);
      2'd3:    t = !r[WIDTH-1] && (r != '0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q == S_IDLE) && slot_free;
  assign busy      = (state_q != S_IDLE);

  // Single-cycle ALU; anything not listed is reported illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SRL:  alu_res = b >> shamt;
      OP_SLL:  alu_res = b << shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      default: alu_ill = 1'b1;
    endcase
  end

  assign mul_acc_nx = acc_q + (opa_q[0] ? opb_q : '0);

`ifdef EXEC_MDU_DIV_EN
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  assign div_trial  = {acc_q, opa_q[WIDTH-1]};
  assign div_ge     = div_trial >= {1'b0, opb_q};
  assign div_rem_nx = div_ge ? (div_trial[WIDTH-1:0] - opb_q) : div_trial[WIDTH-1:0];
  assign div_quo_nx = {opa_q[WIDTH-2:0], div_ge};
`endif

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    cond_d      = cond_q;
`ifdef EXEC_MDU_DIV_EN
    rem_sel_d   = rem_sel_q;
`endif
    out_valid_d = out_valid && !out_ready;
    result_d    = result;
    pc_out_d    = pc_out;
    br_taken_d  = br_taken;
    illegal_d   = illegal_op;
    fin_done    = 1'b0;
    fin_res     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          pc_d   = pc_in;
          tgt_d  = br_target;
          cond_d = br_cond;
          cnt_d  = '0;
          if (op == OP_MUL) begin
            state_d = S_MUL;
            acc_d   = '0;
            opa_d   = b;
            opb_d   = a;
          end
`ifdef EXEC_MDU_DIV_EN
          else if (op == OP_DIVU || op == OP_REMU) begin
            state_d   = S_DIV;
            acc_d     = '0;
            opa_d     = a;
            opb_d     = b;
            rem_sel_d = (op == OP_REMU);
          end
`endif
          else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            br_taken_d  = br_eval(alu_res, br_cond);
            pc_out_d    = br_taken_d ? br_target : pc_in;
            illegal_d   = alu_ill;
          end
        end
      end
      S_MUL: begin
        if (cnt_q != CNT_LAST) begin
          acc_d = mul_acc_nx;
          opa_d = opa_q >> 1;
          opb_d = opb_q << 1;
          cnt_d = cnt_q + CW'(1);
        end else if (slot_free) begin
          fin_done = 1'b1;
          fin_res  = mul_acc_nx;
        end
      end
`ifdef EXEC_MDU_DIV_EN
      S_DIV: begin
        if (cnt_q != CNT_LAST) begin
          acc_d = div_rem_nx;
          opa_d = div_quo_nx;
          cnt_d = cnt_q + CW'(1);
        end else if (slot_free) begin
          fin_done = 1'b1;
          fin_res  = rem_sel_q ? div_rem_nx : div_quo_nx;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Final iteration retires straight into the output register.
    if (fin_done) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      result_d    = fin_res;
      br_taken_d  = br_eval(fin_res, cond_q);
      pc_out_d    = br_taken_d ? tgt_q : pc_q;
      illegal_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      pc_q       <= '0;
      tgt_q      <= '0;
      cond_q     <= '0;
`ifdef EXEC_MDU_DIV_EN
      rem_sel_q  <= 1'b0;
`endif
      out_valid  <= 1'b0;
      result     <= '0;
      pc_out     <= '0;
      br_taken   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      cond_q     <= cond_d;
`ifdef EXEC_MDU_DIV_EN
      rem_sel_q  <= rem_sel_d;
`endif
      out_valid  <= out_valid_d;
      result     <= result_d;
      pc_out     <= pc_out_d;
      br_taken   <= br_taken_d;
      illegal_op <= illegal_d;
    end
  end

endmodule

// File: tb/tb_exec_mdu_unit.sv
// Testbench for exec_mdu_unit (WIDTH=32): table of single-cycle vectors,
// hand-written multi-cycle, backpressure and reset sequences, scoreboarded output.
module tb_exec_mdu_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [4:0]    shamt = '0;
  logic [1:0]    br_cond = '0;
  logic [W-1:0]  pc_in = '0;
  logic [W-1:0]  br_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [W-1:0]  pc_out;
  logic          br_taken;
  logic          illegal_op;
  logic          busy;

  exec_mdu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .shamt(shamt), .br_cond(br_cond), .pc_in(pc_in),
    .br_target(br_target), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .pc_out(pc_out), .br_taken(br_taken),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] pco;
    logic         taken;
    logic         ill;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [1:0]   cond;
    logic [W-1:0] pc;
    logic [W-1:0] tgt;
    exp_t         e;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mke(input logic [W-1:0] r, input logic [W-1:0] p,
                               input logic t, input logic i);
    exp_t e;
    e.res = r; e.pco = p; e.taken = t; e.ill = i;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [4:0] sh, input logic [1:0] c, input logic [W-1:0] pc,
                               input logic [W-1:0] tgt, input logic [W-1:0] r, input logic t,
                               input logic i);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.sh = sh; v.cond = c; v.pc = pc; v.tgt = tgt;
    v.e = mke(r, t ? tgt : pc, t, i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every transfer pops and compares the oldest expectation.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_result: got result 0x%0h with no request outstanding, expected none", result);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", 64'(result), 64'(mon_e.res));
        chk("pc_out", 64'(pc_out), 64'(mon_e.pco));
        chk("br_taken", 64'(br_taken), 64'(mon_e.taken));
        chk("illegal_op", 64'(illegal_op), 64'(mon_e.ill));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [4:0] sh, input logic [1:0] c, input logic [W-1:0] pc,
                       input logic [W-1:0] tgt, input exp_t e, input bit push, input bit ordy,
                       output int waits);
    @(negedge clk);
    op = o; a = ia; b = ib; shamt = sh; br_cond = c; pc_in = pc; br_target = tgt;
    in_valid = 1'b1;
    out_ready = ordy;
    #1;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 after 200 cycles, expected 1");
      in_valid = 1'b0;
    end else if (push) begin
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Waits for out_valid after an accept; reports latency and busy/in_ready history.
  task automatic wait_out(input bit ordy_after, output int lat, output int bcnt, output int irc);
    lat = 0; bcnt = 0; irc = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        out_ready = ordy_after;
      end
      #3;
      if (out_valid) begin
        lat = n;
        break;
      end
      bcnt += int'(busy);
      irc += int'(in_ready);
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid 0 after 80 cycles, expected 1");
    end
  endtask

  task automatic do_mc(input string name, input logic [3:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [1:0] c, input logic [W-1:0] pc,
                       input logic [W-1:0] tgt, input logic [W-1:0] r, input logic t);
    int w, lat, bc, ir;
    issue(o, ia, ib, 5'd0, c, pc, tgt, mke(r, t ? tgt : pc, t, 1'b0), 1'b1, 1'b1, w);
    wait_out(1'b1, lat, bc, ir);
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_busy_cycles"}, 64'(bc), 64'd32);
    chk({name, "_in_ready_while_busy"}, 64'(ir), 64'd0);
    chk({name, "_busy_at_result"}, 64'(busy), 64'd0);
    drain();
  endtask

  vec_t vt[18];

  initial begin
    int w, lat, bc, ir, seen;

    vt[0]  = mkv(4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  2'd1, 32'h100, 32'h200, 32'h00000000, 1'b1, 1'b0);
    vt[1]  = mkv(4'd1,  32'h00000005, 32'h00000007, 5'd0,  2'd2, 32'h104, 32'h300, 32'hFFFFFFFE, 1'b1, 1'b0);
    vt[2]  = mkv(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  2'd0, 32'h108, 32'h808, 32'hF000F000, 1'b0, 1'b0);
    vt[3]  = mkv(4'd3,  32'h0F0F0000, 32'h000000F0, 5'd0,  2'd3, 32'h10C, 32'h80C, 32'h0F0F00F0, 1'b1, 1'b0);
    vt[4]  = mkv(4'd4,  32'hAAAA5555, 32'hFFFF0000, 5'd0,  2'd0, 32'h110, 32'h810, 32'h55555555, 1'b0, 1'b0);
    vt[5]  = mkv(4'd5,  32'h00000000, 32'h00000000, 5'd0,  2'd3, 32'h114, 32'h814, 32'hFFFFFFFF, 1'b0, 1'b0);
    vt[6]  = mkv(4'd6,  32'h00000000, 32'h80000000, 5'd31, 2'd3, 32'h118, 32'h818, 32'h00000001, 1'b1, 1'b0);
    vt[7]  = mkv(4'd7,  32'h00000000, 32'h00000001, 5'd31, 2'd2, 32'h11C, 32'h81C, 32'h80000000, 1'b1, 1'b0);
    vt[8]  = mkv(4'd8,  32'h12345678, 32'h80000000, 5'd4,  2'd0, 32'h120, 32'h820, 32'hF8000000, 1'b0, 1'b0);
    vt[9]  = mkv(4'd9,  32'hFFFFFFFF, 32'h00000001, 5'd0,  2'd1, 32'h124, 32'h824, 32'h00000001, 1'b0, 1'b0);
    vt[10] = mkv(4'd10, 32'hFFFFFFFF, 32'h00000001, 5'd0,  2'd1, 32'h128, 32'h828, 32'h00000000, 1'b1, 1'b0);
    vt[11] = mkv(4'd14, 32'h00000001, 32'h00000002, 5'd0,  2'd0, 32'h12C, 32'h82C, 32'h00000000, 1'b0, 1'b1);
    vt[12] = mkv(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  2'd2, 32'h130, 32'h830, 32'h00000000, 1'b0, 1'b1);
    vt[13] = mkv(4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  2'd3, 32'h134, 32'h834, 32'h80000000, 1'b0, 1'b0);
    vt[14] = mkv(4'd8,  32'h00000000, 32'h40000000, 5'd1,  2'd0, 32'h138, 32'h838, 32'h20000000, 1'b0, 1'b0);
    vt[15] = mkv(4'd9,  32'h00000001, 32'hFFFFFFFF, 5'd0,  2'd0, 32'h13C, 32'h83C, 32'h00000000, 1'b0, 1'b0);
    vt[16] = mkv(4'd10, 32'h00000001, 32'hFFFFFFFF, 5'd0,  2'd0, 32'h140, 32'h840, 32'h00000001, 1'b0, 1'b0);
    vt[17] = mkv(4'd6,  32'h00000000, 32'hFFFFFFFF, 5'd0,  2'd2, 32'h144, 32'h844, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    chk("rst_br_taken", 64'(br_taken), 64'd0);
    chk("rst_illegal_op", 64'(illegal_op), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Back-to-back single-cycle table: one accept and one result per cycle.
    for (int i = 0; i < 18; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].cond, vt[i].pc, vt[i].tgt,
            vt[i].e, 1'b1, 1'b1, w);
      chk("sc_accept_wait", 64'(w), 64'd0);
      if (i > 0) chk("sc_throughput_valid", 64'(out_valid), 64'd1);
    end
    idle();
    drain();

    // Multiplier latency, busy window and products.
    do_mc("mul_10001", 4'd11, 32'h00010001, 32'h00010001, 2'd2, 32'h400, 32'h500, 32'h00020001, 1'b1);
    do_mc("mul_ones",  4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 32'h404, 32'h504, 32'h00000001, 1'b0);
    do_mc("mul_zero",  4'd11, 32'h12345678, 32'h00000000, 2'd1, 32'h408, 32'h508, 32'h00000000, 1'b1);
    do_mc("mul_neg",   4'd11, 32'h0000FFFF, 32'h00010001, 2'd3, 32'h40C, 32'h50C, 32'hFFFFFFFF, 1'b0);
    do_mc("mul_nine",  4'd11, 32'h12345678, 32'h00000009, 2'd0, 32'h410, 32'h510, 32'hA3D70A38, 1'b0);

`ifdef EXEC_MDU_DIV_EN
    do_mc("divu",      4'd12, 32'd100,      32'd7,        2'd0, 32'h600, 32'h700, 32'd14,        1'b0);
    do_mc("remu",      4'd13, 32'd100,      32'd7,        2'd2, 32'h604, 32'h704, 32'd2,         1'b1);
    do_mc("divu_zero", 4'd12, 32'd5,        32'd0,        2'd1, 32'h608, 32'h708, 32'hFFFFFFFF,  1'b0);
    do_mc("remu_zero", 4'd13, 32'd5,        32'd0,        2'd0, 32'h60C, 32'h70C, 32'd5,         1'b0);
    do_mc("divu_big",  4'd12, 32'hFFFFFFFF, 32'h10,       2'd0, 32'h610, 32'h710, 32'h0FFFFFFF,  1'b0);
    do_mc("remu_big",  4'd13, 32'hFFFFFFFF, 32'h10,       2'd0, 32'h614, 32'h714, 32'h0000000F,  1'b0);
`else
    // Divide opcodes are illegal and single-cycle without the divider.
    issue(4'd12, 32'd100, 32'd7, 5'd0, 2'd0, 32'h600, 32'h700,
          mke(32'd0, 32'h600, 1'b0, 1'b1), 1'b1, 1'b1, w);
    idle();
    #3;
    chk("divu_off_latency", 64'(out_valid), 64'd1);
    chk("divu_off_busy", 64'(busy), 64'd0);
    drain();
    issue(4'd13, 32'd100, 32'd7, 5'd0, 2'd0, 32'h604, 32'h704,
          mke(32'd0, 32'h604, 1'b0, 1'b1), 1'b1, 1'b1, w);
    idle();
    #3;
    chk("remu_off_latency", 64'(out_valid), 64'd1);
    drain();
`endif

    // Backpressure on a single-cycle result, then simultaneous drain and accept.
    issue(4'd0, 32'd1, 32'd2, 5'd0, 2'd0, 32'h900, 32'hA00, mke(32'd3, 32'h900, 1'b0, 1'b0), 1'b1, 1'b0, w);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'd3);
      chk("hold_pc_out", 64'(pc_out), 64'h900);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    issue(4'd0, 32'd10, 32'd20, 5'd0, 2'd2, 32'h904, 32'hA04, mke(32'd30, 32'hA04, 1'b1, 1'b0), 1'b1, 1'b1, w);
    chk("release_accept_wait", 64'(w), 64'd0);
    chk("release_old_valid", 64'(out_valid), 64'd1);
    idle();
    drain();

    // Multiplier result held under backpressure, delivered exactly once.
    issue(4'd11, 32'd7, 32'd6, 5'd0, 2'd3, 32'hB00, 32'hC00, mke(32'd42, 32'hC00, 1'b1, 1'b0), 1'b1, 1'b1, w);
    wait_out(1'b0, lat, bc, ir);
    chk("mul_hold_latency", 64'(lat), 64'd33);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #3;
      chk("mul_hold_valid", 64'(out_valid), 64'd1);
      chk("mul_hold_result", 64'(result), 64'd42);
      chk("mul_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("mul_no_duplicate", 64'(out_valid), 64'd0);
    chk("mul_hold_drained", 64'(sbq.size()), 64'd0);

    // Reset ten cycles into a multiply, with a competing request in the reset cycle.
    issue(4'd11, 32'd3, 32'd5, 5'd0, 2'd0, 32'hD00, 32'hE00, mke(32'd15, 32'hD00, 1'b0, 1'b0), 1'b0, 1'b1, w);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #3;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #3;
      seen += int'(out_valid);
    end
    chk("abort_no_stray", 64'(seen), 64'd0);

    // Unit still operational after the abort.
    issue(4'd0, 32'd2, 32'd2, 5'd0, 2'd2, 32'hF00, 32'hF80, mke(32'd4, 32'hF80, 1'b1, 1'b0), 1'b1, 1'b1, w);
    chk("post_reset_accept_wait", 64'(w), 64'd0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
